// File: rtl/fbm_pkg.sv
// Shared buffer-index type for the frame buffer manager.
// Latency: none (types and helpers only).
// Backpressure: n/a.
package fbm_pkg;

  localparam int BUF_BITS = 2;

  typedef logic [BUF_BITS-1:0] buf_idx_t;

  // With three buffers numbered 0..2, the one not named by a or b is 3-a-b.
  function automatic buf_idx_t free_idx(input buf_idx_t a, input buf_idx_t b);
    return buf_idx_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/fbm_buffer_select.sv
// Buffer index / handshake state for the frame store (optional stats via FBM_STATS_EN).
// Latency: index and handshake outputs update on the edge after a frame_done/frame_start pulse.
// Backpressure: write_ready drops after frame_done with 2 buffers until the display takes the frame.
import fbm_pkg::*;

module fbm_buffer_select #(
  parameter int NUM_BUFFERS = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     frame_done,
  input  logic     frame_start,
  output logic     write_ready,
  output buf_idx_t wr_idx,
  output buf_idx_t rd_idx,
`ifdef FBM_STATS_EN
  output logic [15:0] frames_dropped,
  output logic [15:0] frames_repeated,
`endif
  output logic     frame_pending
);

  buf_idx_t ready_idx, n_ready_idx, n_wr_idx, n_rd_idx;
  logic     ready_valid, n_ready_valid, n_write_ready;
  logic     done_ok;

  assign done_ok       = frame_done && write_ready;
  assign frame_pending = ready_valid;

  // State register; every output of this block is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx      <= '0;
      rd_idx      <= buf_idx_t'(NUM_BUFFERS - 1);
      ready_idx   <= '0;
      ready_valid <= 1'b0;
      write_ready <= 1'b1;
    end else begin
      wr_idx      <= n_wr_idx;
      rd_idx      <= n_rd_idx;
      ready_idx   <= n_ready_idx;
      ready_valid <= n_ready_valid;
      write_ready <= n_write_ready;
    end
  end

  // Next state: apply frame_done first, then frame_start on the result.
  always_comb begin
    n_wr_idx      = wr_idx;
    n_rd_idx      = rd_idx;
    n_ready_idx   = ready_idx;
    n_ready_valid = ready_valid;
    n_write_ready = write_ready;

    if (done_ok) begin
      n_ready_idx   = wr_idx;
      n_ready_valid = 1'b1;
      if (NUM_BUFFERS == 3) begin
        if (ready_valid)      n_wr_idx = ready_idx;       // drop the unshown frame
        else if (frame_start) n_wr_idx = rd_idx;          // display leaves rd_idx this cycle
        else                  n_wr_idx = free_idx(rd_idx, wr_idx);
      end else begin
        n_write_ready = 1'b0;
      end
    end

    if (frame_start && n_ready_valid) begin
      n_rd_idx      = n_ready_idx;
      n_ready_valid = 1'b0;
      if (NUM_BUFFERS == 2) begin
        n_wr_idx      = rd_idx;
        n_write_ready = 1'b1;
      end
    end
  end

`ifdef FBM_STATS_EN
  logic drop_ev, repeat_ev;

  assign drop_ev   = (NUM_BUFFERS == 3) && done_ok && ready_valid;
  assign repeat_ev = frame_start && !ready_valid && !done_ok;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_dropped  <= '0;
      frames_repeated <= '0;
    end else begin
      if (drop_ev && frames_dropped != 16'hFFFF)    frames_dropped  <= frames_dropped + 16'd1;
      if (repeat_ev && frames_repeated != 16'hFFFF) frames_repeated <= frames_repeated + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port RAM, read-first on port B.
// Latency: 1 cycle from addrb to doutb.
// Backpressure: none; always accepts accesses.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_LEN  = 4,
  parameter int RAM_DEPTH = 1 << ADDR_LEN
) (
  input  logic                 clka,
  input  logic [ADDR_LEN-1:0]  addra,
  input  logic [ADDR_LEN-1:0]  addrb,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [RAM_WIDTH-1:0] dinb,
  input  logic                 wea,
  input  logic                 web,
  input  logic                 ena,
  input  logic                 enb,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Both ports share one clock; port B returns the pre-write contents.
  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
    if (enb && web) mem[addrb] <= dinb;
    if (enb)        doutb      <= mem[addrb];
  end

endmodule

// File: rtl/frame_buffer_manager.sv
// 2/3-buffer frame store between pixel writer and scan-out (stats ports with FBM_STATS_EN).
// Latency: read_data/read_buf 2 cycles after read_addr; index changes 1 cycle after pulses.
// Backpressure: write_ready low (2 buffers only) while a finished frame waits for frame_start.
`ifndef COLOR_BITS
`define COLOR_BITS 12
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 16
`endif

import fbm_pkg::*;

module frame_buffer_manager #(
  parameter int WIDTH       = `COLOR_BITS,
  parameter int ADDR_LEN    = `ADDR_BITS,
  parameter int DEPTH       = 1 << ADDR_LEN,
  parameter int NUM_BUFFERS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_enable,
  input  logic [ADDR_LEN-1:0] write_addr,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                frame_done,
  output logic                write_ready,
  output buf_idx_t            write_buf,
  input  logic                frame_start,
  input  logic [ADDR_LEN-1:0] read_addr,
  output logic [WIDTH-1:0]    read_data,
  output buf_idx_t            read_buf,
`ifdef FBM_STATS_EN
  output logic [15:0]         frames_dropped,
  output logic [15:0]         frames_repeated,
`endif
  output logic                frame_pending
);

  if ((NUM_BUFFERS != 2) && (NUM_BUFFERS != 3)) begin : g_bad_num_buffers
    $error("frame_buffer_manager: NUM_BUFFERS must be 2 or 3");
  end

  buf_idx_t   wr_idx, rd_idx, rd_q1;
  logic [WIDTH-1:0] ram_dout [NUM_BUFFERS];

  assign write_buf = wr_idx;

  fbm_buffer_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_select (
    .clk             (clk),
    .rst             (rst),
    .frame_done      (frame_done),
    .frame_start     (frame_start),
    .write_ready     (write_ready),
    .wr_idx          (wr_idx),
    .rd_idx          (rd_idx),
`ifdef FBM_STATS_EN
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated),
`endif
    .frame_pending   (frame_pending)
  );

  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
    xilinx_true_dual_port_read_first_1_clock_ram #(
      .RAM_WIDTH (WIDTH),
      .ADDR_LEN  (ADDR_LEN),
      .RAM_DEPTH (DEPTH)
    ) u_ram (
      .clka  (clk),
      .addra (write_addr),
      .addrb (read_addr),
      .dina  (write_data),
      .dinb  ('0),
      .wea   (write_enable && write_ready && (wr_idx == buf_idx_t'(i))),
      .web   (1'b0),
      .ena   (1'b1),
      .enb   (1'b1),
      .doutb (ram_dout[i])
    );
  end

  // Index travels alongside the read so the mux never looks at the live rd_idx;
  // reads in flight across a frame_start finish from the old buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q1     <= buf_idx_t'(NUM_BUFFERS - 1);
      read_buf  <= buf_idx_t'(NUM_BUFFERS - 1);
      read_data <= '0;
    end else begin
      rd_q1     <= rd_idx;
      read_buf  <= rd_q1;
      read_data <= ram_dout[rd_q1];
    end
  end

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager: a 3-buffer and a 2-buffer instance on one clock.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: exercises write_ready deassertion on the 2-buffer instance.
import fbm_pkg::*;

module tb_frame_buffer_manager;

  localparam int W  = 8;
  localparam int AL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_we, a_done, a_start, a_wrdy, a_pend;
  logic [AL-1:0] a_waddr, a_raddr;
  logic [W-1:0]  a_wdata, a_rdata;
  buf_idx_t      a_wbuf, a_rbuf;

  logic          b_we, b_done, b_start, b_wrdy, b_pend;
  logic [AL-1:0] b_waddr, b_raddr;
  logic [W-1:0]  b_wdata, b_rdata;
  buf_idx_t      b_wbuf, b_rbuf;

`ifdef FBM_STATS_EN
  logic [15:0] a_dropped, a_repeated, b_dropped, b_repeated;
`endif

  frame_buffer_manager #(.WIDTH(W), .ADDR_LEN(AL), .NUM_BUFFERS(3)) dut3 (
    .clk(clk), .rst(rst),
    .write_enable(a_we), .write_addr(a_waddr), .write_data(a_wdata),
    .frame_done(a_done), .write_ready(a_wrdy), .write_buf(a_wbuf),
    .frame_start(a_start), .read_addr(a_raddr), .read_data(a_rdata), .read_buf(a_rbuf),
`ifdef FBM_STATS_EN
    .frames_dropped(a_dropped), .frames_repeated(a_repeated),
`endif
    .frame_pending(a_pend)
  );

  frame_buffer_manager #(.WIDTH(W), .ADDR_LEN(AL), .NUM_BUFFERS(2)) dut2 (
    .clk(clk), .rst(rst),
    .write_enable(b_we), .write_addr(b_waddr), .write_data(b_wdata),
    .frame_done(b_done), .write_ready(b_wrdy), .write_buf(b_wbuf),
    .frame_start(b_start), .read_addr(b_raddr), .read_data(b_rdata), .read_buf(b_rbuf),
`ifdef FBM_STATS_EN
    .frames_dropped(b_dropped), .frames_repeated(b_repeated),
`endif
    .frame_pending(b_pend)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Straddle expectations: two results from the old buffer, then the new one.
  logic [W-1:0] exp_data [4] = '{8'h0A, 8'h0A, 8'hC2, 8'hC2};
  buf_idx_t     exp_buf  [4] = '{2'd0, 2'd0, 2'd2, 2'd2};

  initial begin
    rst = 1'b1;
    a_we = 0; a_done = 0; a_start = 0; a_waddr = '0; a_raddr = '0; a_wdata = '0;
    b_we = 0; b_done = 0; b_start = 0; b_waddr = '0; b_raddr = '0; b_wdata = '0;
    do_reset();

    // Reset state of both instances.
    check("n3_rst_write_buf", a_wbuf, 0);
    check("n3_rst_read_buf", a_rbuf, 2);
    check("n3_rst_write_ready", a_wrdy, 1);
    check("n3_rst_pending", a_pend, 0);
    check("n3_rst_read_data", a_rdata, 0);
    check("n2_rst_write_buf", b_wbuf, 0);
    check("n2_rst_read_buf", b_rbuf, 1);
    check("n2_rst_write_ready", b_wrdy, 1);

    // N=3 basic write / done / start / read.
    a_we = 1; a_waddr = 4'd5; a_wdata = 8'h0A; tick(); a_we = 0;
    a_done = 1; tick(); a_done = 0;
    check("n3_done_pending", a_pend, 1);
    check("n3_done_write_buf", a_wbuf, 1);
    a_start = 1; tick(); a_start = 0;
    check("n3_start_pending", a_pend, 0);
    a_raddr = 4'd5; tick(); tick();
    check("n3_read_data", a_rdata, 8'h0A);
    check("n3_read_buf", a_rbuf, 0);
    check("n3_write_buf_after", a_wbuf, 1);

    // N=3 two frame_done pulses without a frame_start.
    do_reset();
    a_done = 1; tick(); a_done = 0;
    a_we = 1; a_waddr = 4'd2; a_wdata = 8'h55; tick(); a_we = 0;
    a_done = 1; tick(); a_done = 0;
    check("n3_drop_pending", a_pend, 1);
    check("n3_drop_write_buf", a_wbuf, 0);
`ifdef FBM_STATS_EN
    check("n3_frames_dropped", a_dropped, 1);
`endif
    a_start = 1; tick(); a_start = 0;
    a_raddr = 4'd2; tick(); tick();
    check("n3_drop_read_buf", a_rbuf, 1);
    check("n3_drop_read_data", a_rdata, 8'h55);
    a_start = 1; tick(); a_start = 0;
    check("n3_repeat_pending", a_pend, 0);
`ifdef FBM_STATS_EN
    check("n3_frames_repeated", a_repeated, 1);
`endif
    tick(); tick();
    check("n3_repeat_read_buf", a_rbuf, 1);

    // N=3 simultaneous done and start from reset.
    do_reset();
    a_done = 1; a_start = 1; tick(); a_done = 0; a_start = 0;
    check("n3_both_write_buf", a_wbuf, 2);
    check("n3_both_pending", a_pend, 0);
    check("n3_both_read_buf_early", a_rbuf, 2);
    tick(); tick();
    check("n3_both_read_buf", a_rbuf, 0);

    // Continuous reads straddling a frame_start.
    a_we = 1; a_waddr = 4'd5; a_wdata = 8'hC2; tick(); a_we = 0;
    a_done = 1; tick(); a_done = 0;
    check("n3_strad_write_buf", a_wbuf, 1);
    a_raddr = 4'd5; tick(); tick(); tick();
    check("n3_strad_pre_data", a_rdata, 8'h0A);
    a_start = 1; tick(); a_start = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("n3_strad_data_%0d", k), a_rdata, exp_data[k]);
      check($sformatf("n3_strad_buf_%0d", k), a_rbuf, exp_buf[k]);
      if (k < 3) tick();
    end

    // N=2 back-pressure.
    do_reset();
    b_we = 1; b_waddr = 4'd3; b_wdata = 8'h11; tick(); b_we = 0;
    b_done = 1; tick(); b_done = 0;
    check("n2_done_write_ready", b_wrdy, 0);
    check("n2_done_pending", b_pend, 1);
    b_we = 1; b_waddr = 4'd3; b_wdata = 8'h99; tick(); b_we = 0;
    b_start = 1; tick(); b_start = 0;
    check("n2_start_write_ready", b_wrdy, 1);
    check("n2_start_write_buf", b_wbuf, 1);
    b_raddr = 4'd3; tick(); tick();
    check("n2_read_buf", b_rbuf, 0);
    check("n2_read_data", b_rdata, 8'h11);

    // N=2 simultaneous done and start swaps indices.
    b_we = 1; b_waddr = 4'd3; b_wdata = 8'h22; tick(); b_we = 0;
    b_done = 1; b_start = 1; tick(); b_done = 0; b_start = 0;
    check("n2_both_write_buf", b_wbuf, 0);
    check("n2_both_write_ready", b_wrdy, 1);
    check("n2_both_pending", b_pend, 0);
    tick(); tick();
    check("n2_both_read_buf", b_rbuf, 1);
    check("n2_both_read_data", b_rdata, 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_manager.md
# frame_buffer_manager

Parametrised 2- or 3-buffer frame store between the ray-marcher pixel writer and the VGA/HDMI scan-out reader. The writer fills one buffer and signals `frame_done`; the display signals `frame_start` at vsync and switches atomically to the newest completed frame. With 3 buffers the writer never stalls, and an unshown completed frame is dropped in favour of a newer one. With 2 buffers the writer is back-pressured until the display picks up the frame.

## Interface
Parameters:
- `WIDTH`, `` `COLOR_BITS ``, bits per pixel word
- `ADDR_LEN`, `` `ADDR_BITS ``, address width
- `DEPTH`, `1<<ADDR_LEN`, words per buffer
- `NUM_BUFFERS`, 3; legal values are 2 or 3, anything else is an elaboration-time `$error`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `write_enable`  in  1  pixel write strobe
- `write_addr`  in  ADDR_LEN  pixel write address
- `write_data`  in  WIDTH  pixel write data
- `frame_done`  in  1  one-cycle pulse: the current write buffer is complete
- `write_ready`  out  1  writes and `frame_done` are accepted
- `write_buf`  out  `BUF_BITS`  index of the buffer currently being written
- `frame_start`  in  1  one-cycle pulse at display vsync
- `read_addr`  in  ADDR_LEN  scan-out address
- `read_data`  out  WIDTH  pixel data, 2 cycles after `read_addr`
- `read_buf`  out  `BUF_BITS`  buffer index that produced `read_data`
- `frame_pending`  out  1  a completed frame is waiting for the display

## Operation
- State: `wr_idx`, `rd_idx`, `ready_idx`, `ready_valid`.
- Reset values: `wr_idx`=0, `rd_idx`=NUM_BUFFERS-1, `ready_valid`=0, `write_ready`=1, `read_data`=0, `read_buf` pipeline=NUM_BUFFERS-1.
- Write path:
  - A write lands in buffer `wr_idx` only when `write_enable && write_ready`.
  - A write in the same cycle as `frame_done` goes to the old `wr_idx`, i.e. the frame being completed.
- `frame_done` is ignored when `write_ready`=0.
  - NUM_BUFFERS=3: `ready_idx`←`wr_idx`, `ready_valid`←1.
    - If `ready_valid` was 1, the old ready frame is dropped and `wr_idx`←old `ready_idx`.
    - Otherwise `wr_idx`←3−`rd_idx`−`wr_idx`, the free buffer.
  - NUM_BUFFERS=2: `ready_idx`←`wr_idx`, `ready_valid`←1, `write_ready`←0.
- `frame_start`:
  - If `ready_valid`=1: `rd_idx`←`ready_idx`, `ready_valid`←0.
    - NUM_BUFFERS=2 only: `wr_idx`←old `rd_idx`, `write_ready`←1.
  - If `ready_valid`=0: no change; the current frame is repeated.
- Simultaneous `frame_done` and `frame_start`: evaluate done first, then start, in one cycle. The just-finished frame is displayed immediately.
  - 3 buffers: `rd_idx`←old `wr_idx`, `ready_valid`←0. `wr_idx`←old `ready_idx` if a frame was pending, else old `rd_idx`.
  - 2 buffers: indices swap and `write_ready` stays 1.
- Invariant: `wr_idx`, `rd_idx`, and `ready_idx` (when valid) are pairwise distinct.
- `rst` mid-frame: state returns to reset values and BRAM contents are kept.

## Timing
- Index updates take effect on the clock edge after the pulse. `write_buf`, `write_ready` and `frame_pending` are registered outputs.
- Read latency is 2 cycles. `read_buf` is `rd_idx` sampled with `read_addr` and delayed 2 cycles.
  - Data already in flight at a `frame_start` edge comes from the old buffer, tagged by the old `read_buf`.
- Output mux selects `read_data` using the delayed index, never the live `rd_idx`.

## Configuration
- `FBM_STATS_EN` defined:
  - Adds output ports `frames_dropped` [15:0] and `frames_repeated` [15:0].
  - Both are saturating counters, reset to 0.
  - `frames_dropped` increments on a 3-buffer overwrite of a pending frame.
  - `frames_repeated` increments on `frame_start` with `ready_valid`=0.
- `FBM_STATS_EN` undefined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- `fbm_pkg`: `BUF_BITS`=2 and `buf_idx_t`.
- Sub-module `fbm_buffer_select`: index/handshake state machine, no storage.
- Top level: a generate loop of `NUM_BUFFERS` `xilinx_true_dual_port_read_first_1_clock_ram`.
  - Port A writes, with `wea = write_enable && write_ready && wr_idx==i`.
  - Port B reads.
  - A 2-stage index pipeline drives the output mux.

## Test plan
- Reset, NUM_BUFFERS=3 -> `write_buf`=0, `read_buf`=2, `write_ready`=1, `frame_pending`=0.
- N=3: write 0xA at addr 5, `frame_done`, `frame_start`, read addr 5 -> `read_data`=0xA two cycles later, `read_buf`=0, `write_buf`=1.
- N=3: two `frame_done` pulses, no `frame_start` -> second frame pending in buffer 1, `write_buf`=0; with `FBM_STATS_EN` defined, `frames_dropped`=1.
- N=2: `frame_done` -> `write_ready`=0 and a write to addr 3 is ignored; `frame_start` -> `write_ready`=1, `write_buf`=1, `read_buf`=0.
- N=3: `frame_done` and `frame_start` in the same cycle from reset -> `read_buf`=0, `write_buf`=2, `frame_pending`=0.
- Continuous reads straddling a `frame_start` -> the first 2 results carry the old `read_buf`, later results the new one, with no mixed data.
